flash_mp_seq: RTL and testbench
===============================

Name: flash_mp_seq

Overview:
Sequencing flash memory-protection unit. It accepts multi-page read, program and erase commands from the flash controller. Each page is checked against prioritised region permissions, and one permitted operation per page is issued to the flash PHY interface, waiting for its completion each time. Denied pages terminate the command and are recorded in a poppable error log. The block sits between the flash controller FSMs and the PHY request port.

Parameters:
MpRegions, 8, number of configurable regions; region index MpRegions is the default region (TotalRegions = MpRegions+1)
NumBanks, 2, flash banks; BankW = max(1,$clog2(NumBanks))
AllPagesW, 16, page address width
LenW, 4, burst length field width; page count = req_len_i+1
ErrDepth, 4, error log entries (power of 2, >=2)

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous active-high reset
region_cfgs_i  in  TotalRegions*(2*AllPagesW+4)  per region, LSB first: base[AllPagesW], size[AllPagesW], erase_en, prog_en, rd_en, en
bank_cfgs_i  in  NumBanks  bank-erase enable per bank
req_i  in  1  command valid
req_ready_o  out  1  command accepted when req_i & req_ready_o
req_op_i  in  2  0 read, 1 program, 2 page erase, 3 bank erase
req_addr_i  in  AllPagesW  start page
req_len_i  in  LenW  pages minus one
req_bk_i  in  BankW  bank
done_o  out  1  one-cycle command completion pulse
error_o  out  1  valid with done_o; command denied
flash_req_o  out  1  one-cycle PHY op strobe
flash_op_o  out  2  op for PHY
flash_addr_o  out  AllPagesW  page for PHY
flash_bk_o  out  BankW  bank for PHY
flash_done_i  in  1  PHY op complete
err_valid_o  out  1  error log non-empty
err_addr_o  out  AllPagesW  head entry page
err_bank_o  out  BankW  head entry bank
err_pop_i  in  1  pop head entry when err_valid_o
err_ovfl_o  out  1  sticky: an error was dropped because the log was full

Behaviour:
- Reset: FSM in IDLE, all outputs 0 except req_ready_o=1, log empty, err_ovfl_o=0. A reset mid-command abandons it silently; no done_o is generated.
- States: IDLE, CHECK, ISSUE, WAIT, DONE.
- IDLE: req_ready_o=1. On accept, latch op, addr, bank and remaining=req_len_i, then go to CHECK. req_ready_o=0 in all other states.
- CHECK (1 cycle): region i matches if en & base<=addr<base+size. The sum is computed at AllPagesW+1 bits, so there is no wrap. The lowest matching index wins. If nothing matches, default region MpRegions applies; its base and size are ignored. Permission is en & the rd/prog/erase bit for the op. Bank erase instead uses bank_cfgs_i[bank], and req_bk_i>=NumBanks is denied.
  - Allowed: go to ISSUE.
  - Denied: push {addr, bank} to the log, set err flag, go to DONE.
- ISSUE: flash_req_o=1 for exactly one cycle with op, addr and bank, then go to WAIT. flash_* outputs hold their values until the next ISSUE.
- WAIT: flash_done_i is ignored in all other states. On flash_done_i:
  - Go to DONE if op==bank erase or remaining==0.
  - If addr==all-ones, page overflow: log {addr+1 wrapped=0, bank}, set err flag, go to DONE.
  - Otherwise addr++, remaining--, go to CHECK.
- DONE: done_o=1 and error_o=err flag for one cycle, clear the flag, go to IDLE.
- Latency: an allowed single page gives flash_req_o 2 cycles after accept and done_o 1 cycle after flash_done_i. A denied first page gives done_o 2 cycles after accept.
- Error log: FIFO of depth ErrDepth. Push while full drops the entry and sets err_ovfl_o. Pop and push in the same cycle while full: both succeed and err_ovfl_o is not set. Pop while empty is ignored. err_ovfl_o clears only on reset.

Optional Feature:
FLASH_MP_SEQ_ABORT_EN:
- Defined: adds input abort_i (1 bit).
  - In CHECK or ISSUE (before the strobe), abort_i goes directly to DONE with error_o=1; no log entry.
  - In WAIT, abort is recorded and the block finishes the current page on flash_done_i, then goes to DONE with error_o=1 and issues no further pages.
  - Ignored in IDLE and DONE.
- Undefined: port absent and behaviour as above.

Test Plan:
- Region0 {base 0x10, size 4, en, rd}; read addr 0x11 len 1 -> flash_req_o at 0x11 and 0x12, one done_o, error_o=0.
- Region0 {base 0x10, size 4, rd} and region1 {base 0x10, size 8, prog}; program 0x12 -> region0 wins, denied: done_o with error_o=1, log entry 0x12, no flash_req_o.
- Read 0x13 len 2 with region0 only (default region disabled) -> flash_req_o at 0x13, then 0x14 denied; error_o=1, log addr 0x14.
- Bank erase bank1 with bank_cfgs_i=2'b10, len 5 -> single flash_req_o op 3 bank 1, done_o error_o=0; bank_cfgs_i=2'b01 -> denied.
- Five denied commands with ErrDepth=4 and no pops -> err_ovfl_o=1, log holds first four; pop with push on full -> count stays 4, err_ovfl_o unchanged.
- Read addr 0xFFFF len 1, default region rd-enabled -> flash_req_o 0xFFFF, then overflow error logged with addr 0; rst_i during WAIT -> IDLE, no done_o.

Source files
------------

// File: rtl/flash_mp_seq.sv
// flash_mp_seq - sequencing flash memory-protection unit.
//
// Accepts multi-page read / program / page-erase / bank-erase commands.
// Each page is checked against the prioritised region table, one PHY op per
// permitted page is issued and its completion awaited. A denied page (or a
// page-address overflow) ends the command and is recorded in a poppable log.
//
// Ports:
//   clk_i, rst_i               clock, synchronous active-high reset
//   region_cfgs_i              per region (LSB first): base, size, erase_en,
//                              prog_en, rd_en, en; region MpRegions is default
//   bank_cfgs_i                bank-erase enable per bank
//   req_i/req_ready_o          command handshake
//   req_op_i/addr_i/len_i/bk_i command fields (len = pages - 1)
//   done_o/error_o             one-cycle completion pulse and denial flag
//   flash_req_o/op/addr/bk     one-cycle PHY strobe; fields hold until next op
//   flash_done_i               PHY completion (honoured only while waiting)
//   err_valid_o/addr/bank      error log head
//   err_pop_i                  pop log head
//   err_ovfl_o                 sticky: a log entry was dropped
//
// Optional build macro FLASH_MP_SEQ_ABORT_EN adds input abort_i.

module flash_mp_seq #(
    parameter int MpRegions = 8,
    parameter int NumBanks  = 2,
    parameter int AllPagesW = 16,
    parameter int LenW      = 4,
    parameter int ErrDepth  = 4,
    localparam int TotalRegions = MpRegions + 1,
    localparam int BankW        = (NumBanks > 2) ? $clog2(NumBanks) : 1,
    localparam int RegW         = 2 * AllPagesW + 4
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic [TotalRegions*RegW-1:0] region_cfgs_i,
    input  logic [NumBanks-1:0]          bank_cfgs_i,
    input  logic                         req_i,
    output logic                         req_ready_o,
    input  logic [1:0]                   req_op_i,
    input  logic [AllPagesW-1:0]         req_addr_i,
    input  logic [LenW-1:0]              req_len_i,
    input  logic [BankW-1:0]             req_bk_i,
    output logic                         done_o,
    output logic                         error_o,
    output logic                         flash_req_o,
    output logic [1:0]                   flash_op_o,
    output logic [AllPagesW-1:0]         flash_addr_o,
    output logic [BankW-1:0]             flash_bk_o,
    input  logic                         flash_done_i,
`ifdef FLASH_MP_SEQ_ABORT_EN
    input  logic                         abort_i,
`endif
    output logic                         err_valid_o,
    output logic [AllPagesW-1:0]         err_addr_o,
    output logic [BankW-1:0]             err_bank_o,
    input  logic                         err_pop_i,
    output logic                         err_ovfl_o
);

    localparam int EAW = $clog2(ErrDepth);

    typedef enum logic [2:0] {IDLE, CHECK, ISSUE, WAIT, DONE} state_e;

    state_e               state_q, state_d;
    logic [1:0]           op_q, op_d;
    logic [AllPagesW-1:0] addr_q, addr_d;
    logic [BankW-1:0]     bk_q, bk_d;
    logic [LenW-1:0]      rem_q, rem_d;
    logic                 err_q, err_d;
    logic                 abort_q, abort_d;
    logic [1:0]           fop_q, fop_d;
    logic [AllPagesW-1:0] faddr_q, faddr_d;
    logic [BankW-1:0]     fbk_q, fbk_d;

    logic abort_w;
`ifdef FLASH_MP_SEQ_ABORT_EN
    assign abort_w = abort_i;
`else
    assign abort_w = 1'b0;
`endif

    // Region lookup: lowest matching enabled region wins, else the default.
    logic [RegW-1:0] cfg, sel;
    logic            found, allowed;

    always_comb begin
        cfg   = '0;
        sel   = region_cfgs_i[MpRegions*RegW +: RegW];
        found = 1'b0;
        for (int i = 0; i < MpRegions; i++) begin
            cfg = region_cfgs_i[i*RegW +: RegW];
            // Upper bound compared at AllPagesW+1 bits so base+size cannot wrap.
            if (!found && cfg[RegW-1] && (addr_q >= cfg[AllPagesW-1:0]) &&
                ({1'b0, addr_q} < ({1'b0, cfg[AllPagesW-1:0]} +
                                   {1'b0, cfg[2*AllPagesW-1:AllPagesW]}))) begin
                found = 1'b1;
                sel   = cfg;
            end
        end
        case (op_q)
            2'd0:    allowed = sel[RegW-1] & sel[2*AllPagesW+2];
            2'd1:    allowed = sel[RegW-1] & sel[2*AllPagesW+1];
            2'd2:    allowed = sel[RegW-1] & sel[2*AllPagesW];
            default: allowed = (int'(bk_q) < NumBanks) && bank_cfgs_i[bk_q];
        endcase
    end

    // Error log FIFO; pointers carry an extra wrap bit for full/empty.
    logic [EAW:0]         wr_q, rd_q;
    logic [AllPagesW-1:0] log_addr_q [ErrDepth];
    logic [BankW-1:0]     log_bk_q   [ErrDepth];
    logic                 ovfl_q;
    logic                 push, push_ok, pop, log_full, log_empty;
    logic [AllPagesW-1:0] push_addr;

    assign log_empty = (wr_q == rd_q);
    assign log_full  = (wr_q[EAW] != rd_q[EAW]) && (wr_q[EAW-1:0] == rd_q[EAW-1:0]);
    assign pop       = err_pop_i & ~log_empty;
    // A pop in the same cycle frees the slot, so a push to a full log still lands.
    assign push_ok   = push & (~log_full | pop);

    assign err_valid_o  = ~log_empty;
    assign err_addr_o   = log_addr_q[rd_q[EAW-1:0]];
    assign err_bank_o   = log_bk_q[rd_q[EAW-1:0]];
    assign err_ovfl_o   = ovfl_q;
    assign flash_op_o   = fop_q;
    assign flash_addr_o = faddr_q;
    assign flash_bk_o   = fbk_q;

    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        addr_d      = addr_q;
        bk_d        = bk_q;
        rem_d       = rem_q;
        err_d       = err_q;
        abort_d     = abort_q;
        fop_d       = fop_q;
        faddr_d     = faddr_q;
        fbk_d       = fbk_q;
        req_ready_o = 1'b0;
        flash_req_o = 1'b0;
        done_o      = 1'b0;
        error_o     = 1'b0;
        push        = 1'b0;
        push_addr   = addr_q;
        case (state_q)
            IDLE: begin
                req_ready_o = 1'b1;
                if (req_i) begin
                    op_d    = req_op_i;
                    addr_d  = req_addr_i;
                    bk_d    = req_bk_i;
                    rem_d   = req_len_i;
                    err_d   = 1'b0;
                    abort_d = 1'b0;
                    state_d = CHECK;
                end
            end
            CHECK: begin
                if (abort_w) begin
                    err_d   = 1'b1;
                    state_d = DONE;
                end else if (allowed) begin
                    fop_d   = op_q;
                    faddr_d = addr_q;
                    fbk_d   = bk_q;
                    state_d = ISSUE;
                end else begin
                    push    = 1'b1;
                    err_d   = 1'b1;
                    state_d = DONE;
                end
            end
            ISSUE: begin
                if (abort_w) begin
                    err_d   = 1'b1;
                    state_d = DONE;
                end else begin
                    flash_req_o = 1'b1;
                    state_d     = WAIT;
                end
            end
            WAIT: begin
                if (abort_w) abort_d = 1'b1;
                if (flash_done_i) begin
                    if (abort_w || abort_q) begin
                        err_d   = 1'b1;
                        state_d = DONE;
                    end else if (op_q == 2'd3 || rem_q == '0) begin
                        state_d = DONE;
                    end else if (&addr_q) begin
                        // Next page would wrap: log the wrapped address (0).
                        push      = 1'b1;
                        push_addr = '0;
                        err_d     = 1'b1;
                        state_d   = DONE;
                    end else begin
                        addr_d  = addr_q + 1'b1;
                        rem_d   = rem_q - 1'b1;
                        state_d = CHECK;
                    end
                end
            end
            DONE: begin
                done_o  = 1'b1;
                error_o = err_q;
                err_d   = 1'b0;
                abort_d = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            op_q    <= '0;
            addr_q  <= '0;
            bk_q    <= '0;
            rem_q   <= '0;
            err_q   <= 1'b0;
            abort_q <= 1'b0;
            fop_q   <= '0;
            faddr_q <= '0;
            fbk_q   <= '0;
            wr_q    <= '0;
            rd_q    <= '0;
            ovfl_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            addr_q  <= addr_d;
            bk_q    <= bk_d;
            rem_q   <= rem_d;
            err_q   <= err_d;
            abort_q <= abort_d;
            fop_q   <= fop_d;
            faddr_q <= faddr_d;
            fbk_q   <= fbk_d;
            if (push_ok) wr_q <= wr_q + 1'b1;
            if (pop)     rd_q <= rd_q + 1'b1;
            if (push && !push_ok) ovfl_q <= 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_ok) begin
            log_addr_q[wr_q[EAW-1:0]] <= push_addr;
            log_bk_q[wr_q[EAW-1:0]]   <= bk_q;
        end
    end

endmodule

// File: tb/tb_flash_mp_seq.sv
module tb_flash_mp_seq;
    localparam int MpRegions = 8;
    localparam int NumBanks  = 2;
    localparam int W         = 16;
    localparam int LenW      = 4;
    localparam int ErrDepth  = 4;
    localparam int TR        = MpRegions + 1;
    localparam int RegW      = 2 * W + 4;
    localparam int BankW     = 1;

    logic clk = 1'b0;
    logic rst_i = 1'b1;
    always #5 clk = ~clk;

    logic [TR*RegW-1:0]  region_cfgs_i = '0;
    logic [NumBanks-1:0] bank_cfgs_i = '0;
    logic                req_i = 1'b0, req_ready_o;
    logic [1:0]          req_op_i = '0;
    logic [W-1:0]        req_addr_i = '0;
    logic [LenW-1:0]     req_len_i = '0;
    logic [BankW-1:0]    req_bk_i = '0;
    logic                done_o, error_o, flash_req_o;
    logic [1:0]          flash_op_o;
    logic [W-1:0]        flash_addr_o;
    logic [BankW-1:0]    flash_bk_o;
    logic                flash_done_i = 1'b0;
    logic                err_valid_o, err_ovfl_o;
    logic [W-1:0]        err_addr_o;
    logic [BankW-1:0]    err_bank_o;
    logic                err_pop_i = 1'b0;

    flash_mp_seq #(.MpRegions(MpRegions), .NumBanks(NumBanks), .AllPagesW(W),
                   .LenW(LenW), .ErrDepth(ErrDepth)) dut (
        .clk_i(clk), .rst_i(rst_i), .region_cfgs_i(region_cfgs_i),
        .bank_cfgs_i(bank_cfgs_i), .req_i(req_i), .req_ready_o(req_ready_o),
        .req_op_i(req_op_i), .req_addr_i(req_addr_i), .req_len_i(req_len_i),
        .req_bk_i(req_bk_i), .done_o(done_o), .error_o(error_o),
        .flash_req_o(flash_req_o), .flash_op_o(flash_op_o),
        .flash_addr_o(flash_addr_o), .flash_bk_o(flash_bk_o),
        .flash_done_i(flash_done_i),
`ifdef FLASH_MP_SEQ_ABORT_EN
        .abort_i(1'b0),
`endif
        .err_valid_o(err_valid_o), .err_addr_o(err_addr_o),
        .err_bank_o(err_bank_o), .err_pop_i(err_pop_i), .err_ovfl_o(err_ovfl_o));

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Region table as the software would program it.
    logic [W-1:0] r_base [TR];
    logic [W-1:0] r_size [TR];
    bit r_en [TR], r_rd [TR], r_pg [TR], r_er [TR];

    task automatic clear_regions();
        for (int i = 0; i < TR; i++) begin
            r_base[i] = '0; r_size[i] = '0;
            r_en[i] = 0; r_rd[i] = 0; r_pg[i] = 0; r_er[i] = 0;
        end
    endtask

    task automatic set_region(input int i, input int base, input int size,
                              input bit en, input bit rd, input bit pg, input bit er);
        r_base[i] = W'(base); r_size[i] = W'(size);
        r_en[i] = en; r_rd[i] = rd; r_pg[i] = pg; r_er[i] = er;
    endtask

    task automatic apply_cfg();
        for (int i = 0; i < TR; i++)
            region_cfgs_i[i*RegW +: RegW] = {r_en[i], r_rd[i], r_pg[i], r_er[i], r_size[i], r_base[i]};
    endtask

    // Reference model: permission, per-command page walk, error log.
    function automatic bit allowed(input int op, input int a, input int bk);
        int r;
        if (op == 3) return (bk < NumBanks) && bank_cfgs_i[bk];
        r = MpRegions;
        for (int i = MpRegions - 1; i >= 0; i--)
            if (r_en[i] && a >= int'(r_base[i]) && a < int'(r_base[i]) + int'(r_size[i])) r = i;
        case (op)
            0:       return r_en[r] && r_rd[r];
            1:       return r_en[r] && r_pg[r];
            default: return r_en[r] && r_er[r];
        endcase
    endfunction

    logic [W+BankW-1:0]   log_q [$];
    bit                   ovfl_m = 0;
    logic [2+W+BankW-1:0] exp_ops [$];
    logic [2+W+BankW-1:0] obs_ops [$];
    bit                   exp_err, obs_err;
    int                   first_req, fd_cyc, done_cyc;

    function automatic void log_push(input int a, input int bk);
        if (log_q.size() < ErrDepth) log_q.push_back({W'(a), BankW'(bk)});
        else ovfl_m = 1;
    endfunction

    function automatic void model_cmd(input int op, input int addr, input int len, input int bk);
        int a = addr;
        int rem = len;
        exp_ops.delete();
        exp_err = 0;
        forever begin
            if (!allowed(op, a, bk)) begin log_push(a, bk); exp_err = 1; break; end
            exp_ops.push_back({2'(op), W'(a), BankW'(bk)});
            if (op == 3 || rem == 0) break;
            if (a == (1 << W) - 1) begin log_push(0, bk); exp_err = 1; break; end
            a++; rem--;
        end
    endfunction

    task automatic check_log();
        chk("err_valid", err_valid_o, log_q.size() != 0);
        if (log_q.size() != 0) chk("err_head", {err_addr_o, err_bank_o}, log_q[0]);
        chk("err_ovfl", err_ovfl_o, ovfl_m);
    endtask

    task automatic do_reset();
        @(negedge clk); rst_i = 1'b1;
        @(negedge clk); @(negedge clk); rst_i = 1'b0;
        log_q.delete(); ovfl_m = 0;
    endtask

    task automatic pop_one();
        @(negedge clk); err_pop_i = 1'b1;
        @(negedge clk); err_pop_i = 1'b0;
        if (log_q.size() != 0) void'(log_q.pop_front());
        check_log();
    endtask

    // Drive one command, act as the PHY with random completion delay, and
    // compare ops, error and log against the model. pop_chk pops the log
    // during the first check cycle (same edge as a first-page denial push).
    task automatic run_cmd(input int op, input int addr, input int len, input int bk, input bit pop_chk);
        int k = 0, cnt = 0;
        bit pending = 0, got_done = 0;
        apply_cfg();
        if (pop_chk && log_q.size() != 0) void'(log_q.pop_front());
        model_cmd(op, addr, len, bk);
        @(negedge clk);
        chk("ready_idle", req_ready_o, 1);
        req_i = 1'b1; req_op_i = 2'(op); req_addr_i = W'(addr);
        req_len_i = LenW'(len); req_bk_i = BankW'(bk);
        @(posedge clk);
        obs_ops.delete(); first_req = -1; fd_cyc = -1; done_cyc = -1; obs_err = 0;
        while (!got_done && k < 300) begin
            @(negedge clk); k++;
            req_i = 1'b0; flash_done_i = 1'b0;
            err_pop_i = pop_chk && (k == 1);
            if (pending) begin
                if (cnt == 0) begin flash_done_i = 1'b1; pending = 0; fd_cyc = k; end
                else cnt--;
            end
            if (flash_req_o) begin
                obs_ops.push_back({flash_op_o, flash_addr_o, flash_bk_o});
                if (first_req < 0) first_req = k;
                pending = 1; cnt = $urandom_range(0, 3);
            end
            if (done_o) begin got_done = 1; obs_err = error_o; done_cyc = k; end
        end
        flash_done_i = 1'b0; err_pop_i = 1'b0;
        chk("done_seen", got_done, 1);
        chk("num_ops", obs_ops.size(), exp_ops.size());
        for (int i = 0; i < obs_ops.size() && i < exp_ops.size(); i++)
            chk("op_fields", obs_ops[i], exp_ops[i]);
        chk("error_o", obs_err, exp_err);
        check_log();
    endtask

    initial begin
        clear_regions();
        apply_cfg();
        repeat (3) @(negedge clk);
        rst_i = 1'b0;
        @(negedge clk);
        chk("rst_ready", req_ready_o, 1);
        chk("rst_done", done_o, 0);
        chk("rst_freq", flash_req_o, 0);
        chk("rst_faddr", flash_addr_o, 0);
        chk("rst_errv", err_valid_o, 0);
        chk("rst_ovfl", err_ovfl_o, 0);

        // Two-page read inside region 0, default region off.
        clear_regions();
        set_region(0, 'h10, 4, 1, 1, 0, 0);
        run_cmd(0, 'h11, 1, 0, 0);
        chk("lat_first_req", first_req, 2);
        chk("lat_done", done_cyc - fd_cyc, 1);

        // Overlapping regions: lower index wins and denies the program.
        set_region(1, 'h10, 8, 1, 0, 1, 0);
        run_cmd(1, 'h12, 0, 0, 0);
        chk("lat_deny", done_cyc, 2);

        // Second page falls outside region 0.
        clear_regions();
        set_region(0, 'h10, 4, 1, 1, 0, 0);
        run_cmd(0, 'h13, 2, 1, 0);

        // Bank erase: single op regardless of length; then denied bank.
        bank_cfgs_i = 2'b10;
        run_cmd(3, 'h40, 5, 1, 0);
        bank_cfgs_i = 2'b01;
        run_cmd(3, 'h40, 5, 1, 0);

        // Log fill, pop-with-push on full, overflow, drain.
        do_reset();
        clear_regions();
        for (int i = 0; i < 4; i++) run_cmd(0, 'h100 + i, 0, i % 2, 0);
        run_cmd(0, 'h104, 0, 0, 1);
        run_cmd(0, 'h105, 0, 1, 0);
        for (int i = 0; i < 5; i++) pop_one();

        // Page address overflow at the top of the space.
        set_region(MpRegions, 0, 0, 1, 1, 0, 0);
        run_cmd(0, 'hFFFF, 1, 0, 0);

        // Reset while waiting on the PHY: command dropped with no done.
        begin
            bit seen_done = 0, seen_req = 0;
            int k = 0;
            apply_cfg();
            @(negedge clk);
            req_i = 1'b1; req_op_i = 2'd0; req_addr_i = 'h20; req_len_i = 3; req_bk_i = 0;
            @(negedge clk); req_i = 1'b0;
            while (!seen_req && k < 20) begin
                seen_req = flash_req_o; k++;
                if (!seen_req) @(negedge clk);
            end
            chk("rst_wait_req", seen_req, 1);
            @(negedge clk); rst_i = 1'b1;
            @(negedge clk); rst_i = 1'b0;
            log_q.delete(); ovfl_m = 0;
            for (int i = 0; i < 6; i++) begin
                @(negedge clk);
                if (done_o) seen_done = 1;
            end
            chk("rst_no_done", seen_done, 0);
            chk("rst_ready2", req_ready_o, 1);
            check_log();
        end

        // Randomised commands against the model.
        for (int t = 0; t < 60; t++) begin
            int addr;
            clear_regions();
            for (int i = 0; i < TR; i++)
                set_region(i, $urandom_range(0, 'h30), $urandom_range(0, 'h10),
                           $urandom_range(0, 1), $urandom_range(0, 1),
                           $urandom_range(0, 1), $urandom_range(0, 1));
            bank_cfgs_i = NumBanks'($urandom_range(0, 3));
            addr = ($urandom_range(0, 7) == 0) ? ('hFFFF - $urandom_range(0, 2))
                                               : $urandom_range(0, 'h40);
            run_cmd($urandom_range(0, 3), addr, $urandom_range(0, 6),
                    $urandom_range(0, 1), $urandom_range(0, 3) == 0);
            if ($urandom_range(0, 2) == 0) pop_one();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
